apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-outstanding APB4 requester (initiator) that turns a valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns one response per command on a valid/ready response channel.
- Sits between a local controller or test sequencer and APB completer CSR blocks such as the practice CSR slave.
- Honours PREADY wait states and PSLVERR.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of data buses; fixed at 32 because of the 4-bit strobe.
- TIMEOUT_CYCLES, 16, maximum number of PREADY-low ACCESS cycles; used only when the timeout feature is compiled in.

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  4  byte strobes for writes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_slverr  out  1  PSLVERR captured at completion, or timeout
- rsp_timeout  out  1  response was produced by the timeout
- PADDR  out  ADDR_WIDTH  APB address
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  4  APB write strobes
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB completer ready
- PSLVERR  in  1  APB completer error

Behaviour:
- Clocking and reset: one clock, PCLK. PRESETn is asynchronous assert, active-low, with synchronous deassertion expected from the reset source.
- Reset values: state IDLE; PSELx=0, PENABLE=0, PWRITE=0; PADDR=0, PWDATA=0, PSTRB=0; rsp_valid=0; rsp_rdata=0; rsp_slverr=0; rsp_timeout=0; wait counter=0.
- cmd_ready = (state==IDLE) && PRESETn. It is combinational from state, with no dependence on cmd_valid.
- State machine IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - On cmd_valid&&cmd_ready, register PADDR={cmd_addr[AW-1:2],2'b00} (low bits forced to word alignment), PWRITE, PWDATA and PSTRB.
  - PSTRB = cmd_write ? cmd_strb : 4'h0. Reads always drive PSTRB=0.
  - PWDATA = cmd_write ? cmd_wdata : 0.
  - Next state SETUP.
- SETUP: PSELx=1, PENABLE=0. Exactly one cycle, then ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1. PADDR, PWRITE, PWDATA and PSTRB are held stable from SETUP through the last ACCESS cycle.
  - If PREADY=0: stay in ACCESS; the wait counter increments and saturates at its maximum value.
  - If PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA and rsp_slverr = PSLVERR.
  - PREADY=1 also clears the wait counter, sets rsp_valid=1, and deasserts PSELx and PENABLE on the next edge.
  - Next state RESP.
- RESP: rsp_valid=1. rsp_rdata, rsp_slverr and rsp_timeout are held until rsp_ready=1. On rsp_valid&&rsp_ready, clear rsp_valid and return to IDLE.
- Throughput: no command is accepted while a response is pending. There is no back-to-back transfer without passing through IDLE.
- Latency with zero wait states: command accepted at edge 0; SETUP in cycle 1; ACCESS in cycle 2; rsp_valid high in cycle 3. Each PREADY-low cycle adds one cycle.
- APB address and data outputs keep their last values in IDLE. PSELx and PENABLE are both 0 outside SETUP/ACCESS.
- PSLVERR and PRDATA are sampled only on the ACCESS cycle in which PREADY=1.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronously). The in-flight command is dropped and no response is produced.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - If the wait counter reaches TIMEOUT_CYCLES while PREADY=0 in ACCESS, abort the transfer: deassert PSELx and PENABLE and go to RESP.
  - The timeout response carries rsp_slverr=1, rsp_timeout=1 and rsp_rdata=32'hDEAD_BEEF.
  - PREADY=1 on the same cycle as the timeout: PREADY wins and the transfer completes normally.
- Undefined: ACCESS waits indefinitely for PREADY; rsp_timeout is tied to 0; TIMEOUT_CYCLES is ignored.

Decomposition:
- Shared package apb_master_pkg contains:
  - state enum (IDLE, SETUP, ACCESS, RESP)
  - APB_TIMEOUT_RDATA = 32'hDEAD_BEEF
  - a command struct (addr, write, wdata, strb)
  - a response struct (rdata, slverr, timeout)
- No sub-module: the FSM and wait counter live in one module.

Test Plan:
- Write 0x0000_0005 to address 0x00, strb 0xF, PREADY tied 1 -> PSELx high cycles 1–2, PENABLE high cycle 2, PSTRB=0xF; rsp_valid in cycle 3 with rsp_slverr=0 and rsp_rdata=0.
- Read address 0x04 after the write to 0x08 with 0x0000_A55A, then read 0x08 -> PSTRB=0 during the read; rsp_rdata=0x0000_A55A.
- Read with PREADY low for 3 ACCESS cycles, PRDATA=0x1234_5678 -> PADDR/PENABLE stable throughout; rsp_valid in cycle 6; rsp_rdata=0x1234_5678.
- PSLVERR=1 with PREADY=1, and rsp_ready held low for 4 cycles -> rsp_slverr=1 and response held for 4 cycles; cmd_ready=0 until the handshake completes.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY stuck at 0 -> PSELx drops after 16 ACCESS cycles; rsp_timeout=1, rsp_slverr=1, rsp_rdata=0xDEAD_BEEF.
- Assert PRESETn=0 during ACCESS -> PSELx, PENABLE and rsp_valid go to 0 immediately; after release, cmd_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types and constants for the APB requester bridge
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB4 requester, cmd/rsp valid-ready channels
// Optional ACCESS-phase timeout abort is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [3:0]            cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    import apb_master_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    apb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    apb_rsp_t         rsp_q;
    logic             timeout_hit;
    logic             unused_addr_lsbs;

    // Byte-lane bits are dropped: the APB side is always word aligned.
    assign unused_addr_lsbs = ^cmd_addr[1:0];

    assign cmd_ready   = (state == IDLE) && PRESETn;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_slverr  = rsp_q.slverr;
    assign rsp_timeout = rsp_q.timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    // Fires on the TIMEOUT_CYCLES-th PREADY-low ACCESS cycle.
    assign timeout_hit = (int'(wait_cnt) + 1) >= TIMEOUT_CYCLES;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= 4'h0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PADDR  <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_write ? cmd_wdata : '0;
                        PSTRB  <= cmd_write ? cmd_strb : 4'h0;
                        PSELx  <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout landing on the same cycle.
                    if (PREADY) begin
                        rsp_q.rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_q.slverr  <= PSLVERR;
                        rsp_q.timeout <= 1'b0;
                        wait_cnt      <= '0;
                        rsp_valid     <= 1'b1;
                        PSELx         <= 1'b0;
                        PENABLE       <= 1'b0;
                        state         <= RESP;
                    end else if (timeout_hit) begin
                        rsp_q     <= '{rdata: APB_TIMEOUT_RDATA, slverr: 1'b1, timeout: 1'b1};
                        wait_cnt  <= '0;
                        rsp_valid <= 1'b1;
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [3:0]  PSTRB;

    int n_err = 0;
    int n_checks = 0;

    // Command-side view of memory versus what the completer actually saw on the pins.
    logic [31:0] model_mem [16];
    logic [31:0] slave_mem [16];

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic err, input int hold);
        logic [31:0] exp_addr, exp_rd;
        int idx;
        exp_addr = {addr[31:2], 2'b00};
        idx      = int'(addr[5:2]);
        exp_rd   = wr ? 32'h0 : model_mem[idx];
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_wdata = wdata; cmd_strb = strb;
        PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = $urandom;
        check("setup_sel_en", {PSELx, PENABLE}, 2'b10);
        check("setup_addr", PADDR, exp_addr);
        check("setup_write", PWRITE, wr);
        check("setup_strb", PSTRB, wr ? strb : 4'h0);
        check("setup_wdata", PWDATA, wr ? wdata : 32'h0);
        check("busy_cmd_ready", cmd_ready, 0);
        tick();
        for (int i = 0; i <= waits; i++) begin
            check("access_sel_en", {PSELx, PENABLE}, 2'b11);
            check("access_addr", PADDR, exp_addr);
            check("access_wdata", PWDATA, wr ? wdata : 32'h0);
            PREADY  = (i == waits);
            PSLVERR = (i == waits) ? err : 1'($urandom);
            PRDATA  = (i == waits) ? slave_mem[int'(PADDR[5:2])] : $urandom;
            if (i == waits && PWRITE && !err)
                slave_mem[int'(PADDR[5:2])] = merge(slave_mem[int'(PADDR[5:2])], PWDATA, PSTRB);
            tick();
        end
        PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
        if (wr && !err) model_mem[idx] = merge(model_mem[idx], wdata, strb);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_sel_en", {PSELx, PENABLE}, 2'b00);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_slverr", rsp_slverr, err);
        check("rsp_timeout", rsp_timeout, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_slverr", rsp_slverr, err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        cmd_strb = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = $urandom;
            slave_mem[i] = model_mem[i];
        end
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_sel_en", {PSELx, PENABLE, PWRITE}, 3'b000);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_pstrb", PSTRB, 0);
        check("rst_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b000);
        check("rst_rdata", rsp_rdata, 0);
        PRESETn = 1'b1;
        tick();

        do_txn(32'h0000_0000, 1'b1, 32'h0000_0005, 4'hF, 0, 1'b0, 0);
        do_txn(32'h0000_0008, 1'b1, 32'h0000_A55A, 4'hF, 0, 1'b0, 0);
        do_txn(32'h0000_0004, 1'b0, 32'h0, 4'hF, 0, 1'b0, 0);
        do_txn(32'h0000_0008, 1'b0, 32'h0, 4'h0, 0, 1'b0, 0);
        check("readback_a55a", model_mem[2], 32'h0000_A55A);
        model_mem[3] = 32'h1234_5678; slave_mem[3] = 32'h1234_5678;
        do_txn(32'h0000_000C, 1'b0, 32'h0, 4'h0, 3, 1'b0, 0);
        do_txn(32'h0000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b1, 4);
        do_txn(32'h0000_0017, 1'b1, 32'hCAFE_F00D, 4'b0101, 1, 1'b0, 1);
        do_txn(32'h0000_0014, 1'b0, 32'h0, 4'h0, 0, 1'b0, 0);

        for (int t = 0; t < 40; t++)
            do_txn($urandom_range(0, 63), 1'($urandom), $urandom, 4'($urandom),
                   $urandom_range(0, 4), ($urandom_range(0, 7) == 0), $urandom_range(0, 2));

        // Reset in the middle of ACCESS drops the transfer without a response.
        cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_write = 1'b1; cmd_wdata = 32'h5555_AAAA;
        cmd_strb = 4'hF; PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_access", {PSELx, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        check("async_rst_sel_en", {PSELx, PENABLE}, 2'b00);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_cmd_ready", cmd_ready, 0);
        tick();
        PRESETn = 1'b1;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        do_txn(32'h0000_0020, 1'b1, 32'h0BAD_C0DE, 4'hF, 0, 1'b0, 0);
        do_txn(32'h0000_0020, 1'b0, 32'h0, 4'h0, 2, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        cmd_valid = 1'b1; cmd_addr = 32'h24; cmd_write = 1'b0; PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("to_access", {PSELx, PENABLE}, 2'b11);
            tick();
        end
        check("to_sel_en", {PSELx, PENABLE}, 2'b00);
        check("to_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b111);
        check("to_rdata", rsp_rdata, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("to_done", {rsp_valid, cmd_ready}, 2'b01);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
